sh_int_entry: RTL and testbench

- CPU-side interrupt acceptance and exception-entry sequencer; sits directly downstream of the interrupt controller.
- Consumes the controller's pending request, level and vector, and returns the SR interrupt mask, acknowledge and vector-fetch handshakes.
- At an instruction boundary it pushes SR and PC onto the R15 stack, then reads the handler address from VBR+vector*4.
- Finally it loads PC, R15 and SR (I field = accepted level) and releases the pipeline.

---
 rtl/sh_int_entry.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_sh_int_entry.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sh_int_entry.sv
// -----------------------------------------------------------------------------
// sh_int_entry
//
// CPU-side interrupt acceptance and exception-entry sequencer. It sits directly
// downstream of the interrupt controller. At an interruptible instruction
// boundary it accepts the pending request and fetches the vector from the
// controller. It then pushes SR and PC onto the R15 stack and reads the handler
// address from VBR + vector*4. Finally it loads PC, R15 and SR (I field =
// accepted level) and releases the pipeline.
//
// Parameters
//   VEC_TIMEOUT  maximum CE cycles spent waiting for VECT_WAIT to drop
//                (0 disables the timeout)
//   SPUR_VEC     vector substituted when the vector fetch times out
//
// Ports
//   CLK, RST          clock, synchronous active-high reset
//   CE                clock enable; every state element advances only when 1
//   INT_REQ/LVL/VEC   pending request, its level and vector number
//   INT_MASK          SR_IN[7:4], combinational
//   INT_ACK           one-CE-cycle pulse when the vector is latched
//   INT_ACP           high while an entry sequence is in progress
//   VECT_REQ          vector-fetch request to the controller
//   VECT_WAIT         vector not yet valid
//   INST_BOUND        CPU at an interruptible instruction boundary
//   SR_IN/PC_IN/R15_IN/VBR_IN  current CPU context
//   MEM_A/DO/DI/WE/REQ/WAIT    single-master bus port
//   STALL             freezes the CPU pipeline during entry
//   PC_WR/PC_OUT, R15_WR/R15_OUT, SR_WR/SR_OUT  register update strobes/values
// -----------------------------------------------------------------------------
module sh_int_entry #(
    parameter int unsigned VEC_TIMEOUT = 255,
    parameter logic [7:0]  SPUR_VEC    = 8'd24
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        CE,
    input  logic        INT_REQ,
    input  logic [3:0]  INT_LVL,
    input  logic [7:0]  INT_VEC,
    output logic [3:0]  INT_MASK,
    output logic        INT_ACK,
    output logic        INT_ACP,
    output logic        VECT_REQ,
    input  logic        VECT_WAIT,
    input  logic        INST_BOUND,
    input  logic [31:0] SR_IN,
    input  logic [31:0] PC_IN,
    input  logic [31:0] R15_IN,
    input  logic [31:0] VBR_IN,
    output logic [31:0] MEM_A,
    output logic [31:0] MEM_DO,
    input  logic [31:0] MEM_DI,
    output logic        MEM_WE,
    output logic        MEM_REQ,
    input  logic        MEM_WAIT,
    output logic        STALL,
    output logic        PC_WR,
    output logic [31:0] PC_OUT,
    output logic        R15_WR,
    output logic [31:0] R15_OUT,
    output logic        SR_WR,
    output logic [31:0] SR_OUT
);

    typedef enum logic [2:0] {
        IDLE,
        VREQ,
        VWAIT,
        PUSH_SR,
        PUSH_PC,
        RD_VEC,
        COMMIT
    } state_t;

    // The timeout fires on the VWAIT cycle in which the counter already holds
    // VEC_TIMEOUT-1, so exactly VEC_TIMEOUT cycles are spent waiting.
    localparam bit          TMO_EN   = (VEC_TIMEOUT != 0);
    localparam logic [31:0] TMO_LAST = TMO_EN ? 32'(VEC_TIMEOUT - 1) : 32'd0;

    // SR with the I field (bits 7:4) replaced by the accepted level.
    function automatic logic [31:0] sr_with_level(input logic [31:0] sr,
                                                  input logic [3:0]  lvl);
        return {sr[31:8], lvl, sr[3:0]};
    endfunction

    // Handler slot address: VBR + vector*4, modulo 2^32.
    function automatic logic [31:0] vec_addr(input logic [31:0] vbr,
                                             input logic [7:0]  vec);
        return vbr + {22'b0, vec, 2'b00};
    endfunction

    state_t      state, state_nxt;

    logic [31:0] sr_lat,  sr_lat_nxt;
    logic [31:0] pc_lat,  pc_lat_nxt;
    logic [31:0] r15_lat, r15_lat_nxt;
    logic [31:0] vbr_lat, vbr_lat_nxt;
    logic [3:0]  lvl_lat, lvl_lat_nxt;
    logic [7:0]  vec_lat, vec_lat_nxt;
    logic [31:0] cnt,     cnt_nxt;

    logic        ack_nxt;
    logic        vreq_nxt;
    logic        stall_nxt;
    logic        mem_req_nxt;
    logic        mem_we_nxt;
    logic [31:0] mem_a_nxt;
    logic [31:0] mem_do_nxt;
    logic        upd_nxt;
    logic [31:0] pc_out_nxt;
    logic [31:0] r15_out_nxt;
    logic [31:0] sr_out_nxt;
    logic        vec_done;

    assign INT_MASK = SR_IN[7:4];

    // ---- state register ----
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else if (CE) begin
            state <= state_nxt;
        end
    end

    // ---- next-state and next-output logic ----
    always_comb begin
        state_nxt   = state;
        sr_lat_nxt  = sr_lat;
        pc_lat_nxt  = pc_lat;
        r15_lat_nxt = r15_lat;
        vbr_lat_nxt = vbr_lat;
        lvl_lat_nxt = lvl_lat;
        vec_lat_nxt = vec_lat;
        cnt_nxt     = cnt;
        ack_nxt     = 1'b0;
        vreq_nxt    = 1'b0;
        mem_req_nxt = MEM_REQ;
        mem_we_nxt  = MEM_WE;
        mem_a_nxt   = MEM_A;
        mem_do_nxt  = MEM_DO;
        upd_nxt     = 1'b0;
        pc_out_nxt  = PC_OUT;
        r15_out_nxt = R15_OUT;
        sr_out_nxt  = SR_OUT;
        vec_done    = 1'b0;

        case (state)
            IDLE: begin
                if (INT_REQ && INST_BOUND) begin
                    sr_lat_nxt  = SR_IN;
                    pc_lat_nxt  = PC_IN;
                    r15_lat_nxt = R15_IN;
                    vbr_lat_nxt = VBR_IN;
                    lvl_lat_nxt = INT_LVL;
                    vreq_nxt    = 1'b1;
                    state_nxt   = VREQ;
                end
            end

            VREQ: begin
                cnt_nxt   = 32'd0;
                state_nxt = VWAIT;
            end

            VWAIT: begin
                if (!VECT_WAIT) begin
                    vec_lat_nxt = INT_VEC;
                    vec_done    = 1'b1;
                end else if (TMO_EN && (cnt == TMO_LAST)) begin
                    vec_lat_nxt = SPUR_VEC;
                    vec_done    = 1'b1;
                end else begin
                    cnt_nxt = cnt + 32'd1;
                end
                // Bus signals for the SR push are set up on the same edge so
                // the write is presented from the first PUSH_SR cycle.
                if (vec_done) begin
                    ack_nxt     = 1'b1;
                    mem_req_nxt = 1'b1;
                    mem_we_nxt  = 1'b1;
                    mem_a_nxt   = r15_lat - 32'd4;
                    mem_do_nxt  = sr_lat;
                    state_nxt   = PUSH_SR;
                end
            end

            PUSH_SR: begin
                if (!MEM_WAIT) begin
                    mem_a_nxt  = r15_lat - 32'd8;
                    mem_do_nxt = pc_lat;
                    state_nxt  = PUSH_PC;
                end
            end

            PUSH_PC: begin
                if (!MEM_WAIT) begin
                    mem_we_nxt = 1'b0;
                    mem_do_nxt = 32'd0;
                    mem_a_nxt  = vec_addr(vbr_lat, vec_lat);
                    state_nxt  = RD_VEC;
                end
            end

            RD_VEC: begin
                if (!MEM_WAIT) begin
                    mem_req_nxt = 1'b0;
                    mem_a_nxt   = 32'd0;
                    pc_out_nxt  = MEM_DI;
                    r15_out_nxt = r15_lat - 32'd8;
                    sr_out_nxt  = sr_with_level(sr_lat, lvl_lat);
                    upd_nxt     = 1'b1;
                    state_nxt   = COMMIT;
                end
            end

            COMMIT: begin
                // Strobes default low, so they last exactly this CE cycle.
                state_nxt = IDLE;
            end

            default: begin
                state_nxt   = IDLE;
                mem_req_nxt = 1'b0;
                mem_we_nxt  = 1'b0;
            end
        endcase

        stall_nxt = (state_nxt != IDLE);
    end

    // ---- registered outputs and latched context ----
    always_ff @(posedge CLK) begin
        if (RST) begin
            sr_lat  <= 32'd0;
            pc_lat  <= 32'd0;
            r15_lat <= 32'd0;
            vbr_lat <= 32'd0;
            lvl_lat <= 4'd0;
            vec_lat <= 8'd0;
            cnt     <= 32'd0;
            INT_ACK <= 1'b0;
            INT_ACP <= 1'b0;
            VECT_REQ <= 1'b0;
            STALL   <= 1'b0;
            MEM_REQ <= 1'b0;
            MEM_WE  <= 1'b0;
            MEM_A   <= 32'd0;
            MEM_DO  <= 32'd0;
            PC_WR   <= 1'b0;
            R15_WR  <= 1'b0;
            SR_WR   <= 1'b0;
            PC_OUT  <= 32'd0;
            R15_OUT <= 32'd0;
            SR_OUT  <= 32'd0;
        end else if (CE) begin
            sr_lat  <= sr_lat_nxt;
            pc_lat  <= pc_lat_nxt;
            r15_lat <= r15_lat_nxt;
            vbr_lat <= vbr_lat_nxt;
            lvl_lat <= lvl_lat_nxt;
            vec_lat <= vec_lat_nxt;
            cnt     <= cnt_nxt;
            INT_ACK <= ack_nxt;
            INT_ACP <= stall_nxt;
            VECT_REQ <= vreq_nxt;
            STALL   <= stall_nxt;
            MEM_REQ <= mem_req_nxt;
            MEM_WE  <= mem_we_nxt;
            MEM_A   <= mem_a_nxt;
            MEM_DO  <= mem_do_nxt;
            PC_WR   <= upd_nxt;
            R15_WR  <= upd_nxt;
            SR_WR   <= upd_nxt;
            PC_OUT  <= pc_out_nxt;
            R15_OUT <= r15_out_nxt;
            SR_OUT  <= sr_out_nxt;
        end
    end

endmodule

// File: tb/tb_sh_int_entry.sv
// -----------------------------------------------------------------------------
// tb_sh_int_entry
//
// Directed bench for sh_int_entry. Each entry sequence pushes the expected bus
// accesses and the expected commit values to a queue; a cycle-by-cycle loop
// plays the controller and bus slave and pops/compares as the DUT produces
// each completed access and commit.
// -----------------------------------------------------------------------------
module tb_sh_int_entry;

    logic        CLK = 1'b0;
    logic        RST, CE;
    logic        INT_REQ;
    logic [3:0]  INT_LVL;
    logic [7:0]  INT_VEC;
    logic [3:0]  INT_MASK;
    logic        INT_ACK, INT_ACP, VECT_REQ, VECT_WAIT, INST_BOUND;
    logic [31:0] SR_IN, PC_IN, R15_IN, VBR_IN;
    logic [31:0] MEM_A, MEM_DO, MEM_DI;
    logic        MEM_WE, MEM_REQ, MEM_WAIT, STALL;
    logic        PC_WR, R15_WR, SR_WR;
    logic [31:0] PC_OUT, R15_OUT, SR_OUT;

    sh_int_entry #(.VEC_TIMEOUT(4), .SPUR_VEC(8'd24)) dut (
        .CLK(CLK), .RST(RST), .CE(CE),
        .INT_REQ(INT_REQ), .INT_LVL(INT_LVL), .INT_VEC(INT_VEC),
        .INT_MASK(INT_MASK), .INT_ACK(INT_ACK), .INT_ACP(INT_ACP),
        .VECT_REQ(VECT_REQ), .VECT_WAIT(VECT_WAIT), .INST_BOUND(INST_BOUND),
        .SR_IN(SR_IN), .PC_IN(PC_IN), .R15_IN(R15_IN), .VBR_IN(VBR_IN),
        .MEM_A(MEM_A), .MEM_DO(MEM_DO), .MEM_DI(MEM_DI), .MEM_WE(MEM_WE),
        .MEM_REQ(MEM_REQ), .MEM_WAIT(MEM_WAIT), .STALL(STALL),
        .PC_WR(PC_WR), .PC_OUT(PC_OUT), .R15_WR(R15_WR), .R15_OUT(R15_OUT),
        .SR_WR(SR_WR), .SR_OUT(SR_OUT)
    );

    always #5 CLK = ~CLK;

    // kind: 0 = bus write, 1 = bus read, 2 = commit (a=PC, d=R15, e=SR)
    typedef struct {
        int          kind;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] e;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    function automatic exp_t mk(input int k, input logic [31:0] a,
                                input logic [31:0] d, input logic [31:0] e);
        exp_t t;
        t.kind = k;
        t.a    = a;
        t.d    = d;
        t.e    = e;
        return t;
    endfunction

    task automatic check32(input string tag, input logic [31:0] obs,
                           input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic pop_exp(output exp_t e);
        total++;
        assert (sb.size() != 0) else begin
            bad++;
            $error("FAIL sb_underflow observed=empty expected=entry");
        end
        if (sb.size() != 0) e = sb.pop_front();
        else                e = mk(-1, 32'd0, 32'd0, 32'd0);
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // One full entry sequence. vw = VECT_WAIT cycles after VECT_REQ,
    // bw = wait cycles per bus access, spur = expect the timeout vector.
    task automatic run_entry(input logic [31:0] sr, input logic [31:0] pc,
                             input logic [31:0] r15, input logic [31:0] vbr,
                             input logic [31:0] di, input logic [3:0] lvl,
                             input logic [7:0] vec, input int vw, input int bw,
                             input bit ce_freeze, input bit spur,
                             output int stall_len);
        logic [7:0]  v_used;
        logic [31:0] a0, d0;
        logic        we0;
        int          vw_left, bw_left, acks;
        bit          in_acc, seen_commit, done;
        exp_t        e;

        v_used = spur ? 8'd24 : vec;
        sb.push_back(mk(0, r15 - 32'd4, sr, 32'd0));
        sb.push_back(mk(0, r15 - 32'd8, pc, 32'd0));
        sb.push_back(mk(1, vbr + {22'b0, v_used, 2'b00}, 32'd0, 32'd0));
        sb.push_back(mk(2, di, r15 - 32'd8, {sr[31:8], lvl, sr[3:0]}));

        SR_IN = sr; PC_IN = pc; R15_IN = r15; VBR_IN = vbr; MEM_DI = di;
        INT_LVL = lvl; INT_VEC = vec; VECT_WAIT = 1'b1; MEM_WAIT = 1'b0;
        INT_REQ = 1'b1; INST_BOUND = 1'b1; CE = 1'b1;
        check32("int_mask", {28'b0, INT_MASK}, {28'b0, sr[7:4]});

        stall_len = 0; acks = 0; vw_left = -1; bw_left = 0;
        in_acc = 0; seen_commit = 0; done = 0;
        a0 = '0; d0 = '0; we0 = 1'b0;

        for (int cyc = 0; cyc < 400 && !done; cyc++) begin
            step();
            if (cyc == 0) begin
                check32("accept_stall", {31'b0, STALL}, 32'd1);
                check32("accept_acp", {31'b0, INT_ACP}, 32'd1);
                check32("accept_vreq", {31'b0, VECT_REQ}, 32'd1);
            end
            if (STALL) stall_len++;
            if (INT_ACK) begin
                acks++;
                INT_REQ = 1'b0;
            end
            if (VECT_REQ)         vw_left = vw;
            else if (vw_left > 0) vw_left--;
            VECT_WAIT = (vw_left != 0);

            if (MEM_REQ) begin
                if (!in_acc) begin
                    in_acc = 1; bw_left = bw;
                    a0 = MEM_A; d0 = MEM_DO; we0 = MEM_WE;
                    if (ce_freeze && !MEM_WE) begin
                        CE = 1'b0;
                        MEM_WAIT = 1'b0;
                        for (int k = 0; k < 5; k++) begin
                            step();
                            check32("freeze_a", MEM_A, a0);
                            check32("freeze_req", {31'b0, MEM_REQ}, 32'd1);
                            check32("freeze_pcwr", {31'b0, PC_WR}, 32'd0);
                            check32("freeze_stall", {31'b0, STALL}, 32'd1);
                        end
                        CE = 1'b1;
                    end
                end else begin
                    check32("hold_a", MEM_A, a0);
                    check32("hold_do", MEM_DO, d0);
                    check32("hold_we", {31'b0, MEM_WE}, {31'b0, we0});
                end
                if (bw_left > 0) begin
                    MEM_WAIT = 1'b1;
                    bw_left--;
                end else begin
                    MEM_WAIT = 1'b0;
                    in_acc = 0;
                    pop_exp(e);
                    check32("bus_we", {31'b0, MEM_WE}, (e.kind == 0) ? 32'd1 : 32'd0);
                    check32("bus_addr", MEM_A, e.a);
                    if (e.kind == 0) check32("bus_wdata", MEM_DO, e.d);
                end
            end else begin
                MEM_WAIT = 1'b0;
            end

            if (PC_WR) begin
                seen_commit = 1;
                pop_exp(e);
                check32("commit_pc", PC_OUT, e.a);
                check32("commit_r15", R15_OUT, e.d);
                check32("commit_sr", SR_OUT, e.e);
                check32("commit_strobes", {30'b0, R15_WR, SR_WR}, 32'd3);
            end
            if (seen_commit && !STALL) done = 1;
        end
        check32("entry_done", {31'b0, done}, 32'd1);
        check32("ack_count", acks, 32'd1);
        INT_REQ = 1'b0; VECT_WAIT = 1'b1; MEM_WAIT = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  s0, s1, sdummy;
        bit  found;

        RST = 1'b1; CE = 1'b0; INT_REQ = 1'b0; INT_LVL = '0; INT_VEC = '0;
        VECT_WAIT = 1'b1; INST_BOUND = 1'b0; SR_IN = '0; PC_IN = '0;
        R15_IN = '0; VBR_IN = '0; MEM_DI = '0; MEM_WAIT = 1'b0;

        // Reset with CE low must still clear everything.
        step(); step();
        check32("rst_stall", {31'b0, STALL}, 32'd0);
        check32("rst_acp", {31'b0, INT_ACP}, 32'd0);
        check32("rst_memreq", {31'b0, MEM_REQ}, 32'd0);
        check32("rst_mema", MEM_A, 32'd0);
        check32("rst_pcout", PC_OUT, 32'd0);
        check32("rst_srout", SR_OUT, 32'd0);
        check32("rst_strobes", {26'b0, PC_WR, R15_WR, SR_WR, INT_ACK, VECT_REQ, MEM_WE}, 32'd0);
        RST = 1'b0; CE = 1'b1;
        step();

        // Basic entry, zero-wait bus.
        run_entry(32'h0000_0030, 32'h0600_1234, 32'h0600_0100, 32'h0600_0000,
                  32'h0600_4000, 4'd5, 8'h41, 2, 0, 0, 0, s0);
        step();

        // Same entry with 3 wait states per access.
        run_entry(32'h0000_0030, 32'h0600_1234, 32'h0600_0100, 32'h0600_0000,
                  32'h0600_4000, 4'd5, 8'h41, 2, 3, 0, 0, s1);
        check32("stall_growth", s1 - s0, 32'd9);
        step();

        // Vector fetch times out: spurious vector 24 -> VBR+0x60.
        run_entry(32'h1234_5600, 32'h0000_8000, 32'h0000_2000, 32'h0600_0000,
                  32'h0000_9000, 4'd7, 8'h33, 1000, 0, 0, 1, sdummy);
        step();

        // Deferred acceptance, then NMI level 15.
        INT_REQ = 1'b1; INST_BOUND = 1'b0; INT_LVL = 4'hF;
        for (int i = 0; i < 10; i++) begin
            step();
            check32("defer_stall", {30'b0, STALL, VECT_REQ}, 32'd0);
        end
        run_entry(32'h7000_00E3, 32'h0C00_0010, 32'h0C00_0800, 32'h0C00_1000,
                  32'h0C00_2000, 4'hF, 8'h0B, 0, 1, 0, 0, sdummy);
        step();

        // Address wrap-around.
        run_entry(32'h0000_0000, 32'hABCD_0000, 32'h0000_0000, 32'hFFFF_FF00,
                  32'h1111_2222, 4'd2, 8'h40, 1, 0, 0, 0, sdummy);
        step();

        // CE low for 5 cycles inside RD_VEC.
        run_entry(32'h0000_0010, 32'h0000_0444, 32'h0000_1000, 32'h0000_0400,
                  32'h0000_5555, 4'd9, 8'h05, 1, 2, 1, 0, sdummy);
        check32("sb_drained", sb.size(), 32'd0);
        step();

        // Reset during PUSH_PC with the bus stalled.
        SR_IN = 32'h0000_00F0; PC_IN = 32'h0000_1234; R15_IN = 32'h0000_0800;
        VBR_IN = 32'h0; INT_LVL = 4'd4; INT_VEC = 8'h10; VECT_WAIT = 1'b0;
        MEM_WAIT = 1'b0; INT_REQ = 1'b1; INST_BOUND = 1'b1;
        found = 0;
        for (int i = 0; i < 50 && !found; i++) begin
            step();
            if (INT_ACK) INT_REQ = 1'b0;
            if (MEM_REQ && MEM_WE && MEM_A == 32'h0000_07F8) begin
                found = 1;
                MEM_WAIT = 1'b1;
            end
        end
        check32("rst_found_pushpc", {31'b0, found}, 32'd1);
        INT_REQ = 1'b0;
        step();
        check32("rst_pushpc_held", MEM_A, 32'h0000_07F8);
        RST = 1'b1;
        step();
        RST = 1'b0; MEM_WAIT = 1'b0;
        check32("midrst_memreq", {31'b0, MEM_REQ}, 32'd0);
        check32("midrst_stall", {30'b0, STALL, INT_ACP}, 32'd0);
        check32("midrst_mema", MEM_A, 32'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            check32("postrst_quiet", {27'b0, PC_WR, R15_WR, SR_WR, STALL, MEM_REQ}, 32'd0);
        end

        // Recovery after reset.
        run_entry(32'h0000_0030, 32'h0600_1234, 32'h0600_0100, 32'h0600_0000,
                  32'h0600_4000, 4'd5, 8'h41, 2, 0, 0, 0, sdummy);
        check32("sb_drained_end", sb.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
